// File: rtl/wav_stream_ctrl.sv
// WAV data-chunk streamer: forwards header bytes to an external parser, captures the
// 32-bit little-endian chunk size, then packs byte pairs into signed 16-bit PCM samples.
module wav_stream_ctrl #(
    parameter logic [31:0] MAX_BYTES = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  p_data,
    output logic        p_valid,
    input  logic        p_ready,
    output logic        p_rst_n,
    input  logic        hdr_valid,
    input  logic        fmt_error,
    input  logic [15:0] bit_depth,
    input  logic [15:0] num_channels,
    output logic [15:0] m_data,
    output logic        m_chan,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  err_code,
    output logic [31:0] bytes_left
);

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_SIZE, S_STREAM, S_DONE, S_FAULT
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_bytes_left;
    logic [1:0]  r_size_cnt;
    logic [7:0]  r_lo_byte;
    logic        r_have_lo;
    logic [15:0] r_m_data;
    logic        r_m_valid;
    logic        r_m_chan;
    logic        r_m_last;
    logic        r_stereo;
    logic [1:0]  r_err;
    logic [1:0]  w_err;

    logic [31:0] w_size;
    logic        w_hdr_bad;
    logic        w_stream_rdy;
    logic        w_acc;
    logic        w_hs;

    assign w_size       = {s_data, r_bytes_left[31:8]};
    assign w_hdr_bad    = (bit_depth != 16'd16) ||
                          !((num_channels == 16'd1) || (num_channels == 16'd2));
    // No byte is taken once the chunk is exhausted, even while the last sample drains.
    assign w_stream_rdy = (r_bytes_left != 32'd0) && (!r_m_valid || m_ready);
    assign w_acc        = (r_state == S_STREAM) && s_valid && w_stream_rdy;
    assign w_hs         = r_m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_err   = 2'd0;
        s_ready = 1'b0;
        p_data  = 8'h00;
        p_valid = 1'b0;
        p_rst_n = 1'b0;
        busy    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_HEADER;
            end
            S_HEADER: begin
                busy    = 1'b1;
                p_rst_n = 1'b1;
                p_data  = s_data;
                p_valid = s_valid;
                s_ready = p_ready;
                if (fmt_error) begin
                    w_next = S_FAULT;
                    w_err  = 2'd1;
                end else if (hdr_valid) begin
                    if (w_hdr_bad) begin
                        w_next = S_FAULT;
                        w_err  = 2'd2;
                    end else begin
                        w_next = S_SIZE;
                    end
                end
            end
            S_SIZE: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid && (r_size_cnt == 2'd3)) begin
                    // Widened compare keeps the check meaningful for any MAX_BYTES.
                    if (w_size == 32'd0) begin
                        w_next = S_DONE;
                    end else if ({1'b0, w_size} > {1'b0, MAX_BYTES}) begin
                        w_next = S_FAULT;
                        w_err  = 2'd3;
                    end else begin
                        w_next = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                busy    = 1'b1;
                s_ready = w_stream_rdy;
                if (w_hs && r_m_last)
                    w_next = S_DONE;
                else if (w_acc && (r_bytes_left == 32'd1) && !r_have_lo)
                    w_next = S_DONE;
            end
            S_DONE:  ;
            S_FAULT: ;
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bytes_left <= 32'd0;
            r_size_cnt   <= 2'd0;
            r_lo_byte    <= 8'h00;
            r_have_lo    <= 1'b0;
            r_m_data     <= 16'h0000;
            r_m_valid    <= 1'b0;
            r_m_chan     <= 1'b0;
            r_m_last     <= 1'b0;
            r_stereo     <= 1'b0;
            r_err        <= 2'd0;
        end else if (abort) begin
            r_bytes_left <= 32'd0;
            r_size_cnt   <= 2'd0;
            r_have_lo    <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_chan     <= 1'b0;
            r_m_last     <= 1'b0;
            r_err        <= 2'd0;
        end else begin
            if ((w_next == S_FAULT) && (r_state != S_FAULT)) r_err <= w_err;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bytes_left <= 32'd0;
                        r_size_cnt   <= 2'd0;
                        r_have_lo    <= 1'b0;
                        r_m_chan     <= 1'b0;
                        r_m_last     <= 1'b0;
                        r_stereo     <= 1'b0;
                    end
                end
                S_HEADER: begin
                    if (hdr_valid) r_stereo <= (num_channels == 16'd2);
                end
                S_SIZE: begin
                    if (s_valid) begin
                        r_bytes_left <= w_size;
                        r_size_cnt   <= r_size_cnt + 2'd1;
                    end
                end
                S_STREAM: begin
                    if (w_hs) begin
                        r_m_valid <= 1'b0;
                        if (r_stereo) r_m_chan <= ~r_m_chan;
                    end
                    // A load in the same cycle as a handshake overrides the clear above.
                    if (w_acc) begin
                        r_bytes_left <= r_bytes_left - 32'd1;
                        if (r_have_lo) begin
                            r_m_data  <= {s_data, r_lo_byte};
                            r_m_valid <= 1'b1;
                            r_m_last  <= (r_bytes_left == 32'd1);
                            r_have_lo <= 1'b0;
                        end else begin
                            r_lo_byte <= s_data;
                            r_have_lo <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;
    assign m_chan     = r_m_chan;
    assign m_last     = r_m_last;
    assign bytes_left = r_bytes_left;
    assign err_code   = r_err;
    assign done       = (r_state == S_DONE);
    assign fault      = (r_state == S_FAULT);

endmodule

// File: tb/tb_wav_stream_ctrl.sv
// Bench for wav_stream_ctrl: random and directed WAV files; expected samples come
// from a byte-array model and are popped by an independent output monitor.
module tb_wav_stream_ctrl;

    localparam logic [31:0] MAXB = 32'h0000_0100;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0, s_ready;
    logic [7:0]  p_data;
    logic        p_valid, p_rst_n;
    logic        p_ready = 1'b1;
    logic        hdr_valid = 1'b0, fmt_error = 1'b0;
    logic [15:0] bit_depth = 16'd16, num_channels = 16'd1;
    logic [15:0] m_data;
    logic        m_chan, m_last, m_valid;
    logic        m_ready = 1'b0;
    logic        busy, done, fault;
    logic [1:0]  err_code;
    logic [31:0] bytes_left;

    wav_stream_ctrl #(.MAX_BYTES(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready), .p_rst_n(p_rst_n),
        .hdr_valid(hdr_valid), .fmt_error(fmt_error),
        .bit_depth(bit_depth), .num_channels(num_channels),
        .m_data(m_data), .m_chan(m_chan), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .fault(fault),
        .err_code(err_code), .bytes_left(bytes_left)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    int          rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high
    bit          intr = 1'b0;
    logic [17:0] exp_q[$];       // {data, chan, last}
    logic [7:0]  fb[$];          // data-chunk bytes of the current file
    logic [7:0]  hdr_b[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // m_ready changes only shortly after the rising edge, never near the sampling edge.
    initial forever begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0:       m_ready = ($urandom_range(0, 3) != 0);
            1:       m_ready = 1'b0;
            default: m_ready = 1'b1;
        endcase
    end

    logic [17:0] cur, prev;
    logic        pend_prev = 1'b0;
    assign cur = {m_data, m_chan, m_last};

    always @(negedge clk) begin
        chk("done_fault_excl", 32'(done & fault), 32'd0);
        if (!fault) chk("err_zero_outside_fault", 32'(err_code), 32'd0);
        if (pend_prev && !intr) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_sample", 32'(cur), 32'(prev));
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_sample: got 0x%0h, expected none (t=%0t)", cur, $time);
            end else begin
                chk("sample", 32'(cur), 32'(exp_q.pop_front()));
            end
        end
        pend_prev <= m_valid && !m_ready;
        prev      <= cur;
    end

    task automatic fill_rand(input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(0, 255)));
    endtask

    // Sample k is bytes 2k (low) and 2k+1 (high); a trailing odd byte yields nothing.
    task automatic push_model(input bit st, input int n);
        for (int k = 0; k < n / 2; k++)
            exp_q.push_back({fb[2*k+1], fb[2*k], (st ? k[0] : 1'b0),
                             ((n % 2 == 0) && (k == n / 2 - 1))});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit hdr);
        int gap = $urandom_range(0, 2);
        bit ok = 1'b0;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1'b1; break; end
        end
        chk("s_ready_seen", 32'(ok), 32'd1);
        if (hdr && ok) begin
            chk("hdr_p_valid", 32'(p_valid), 32'd1);
            chk("hdr_p_data", 32'(p_data), 32'(b));
            chk("hdr_p_rst_n", 32'(p_rst_n), 32'd1);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic do_abort();
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'({busy, done, fault, m_valid, p_rst_n, s_ready}), 32'd0);
        chk("abort_err", 32'(err_code), 32'd0);
        chk("abort_bytes_left", bytes_left, 32'd0);
    endtask

    task automatic begin_file(input logic [15:0] bd, input logic [15:0] nc, input logic [31:0] sz);
        do_start();
        for (int i = 0; i < 4; i++) send_byte(hdr_b[i], 1'b1);
        @(negedge clk);
        chk("hdr_idle_p_valid", 32'(p_valid), 32'd0);
        chk("hdr_busy", 32'(busy), 32'd1);
        bit_depth = bd; num_channels = nc; hdr_valid = 1'b1;
        @(posedge clk); #1;
        hdr_valid = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(sz[8*i +: 8], 1'b0);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        chk("done_reached", 32'(seen), 32'd1);
    endtask

    task automatic run_file(input bit st, input int stall_at);
        int n = fb.size();
        int save;
        push_model(st, n);
        begin_file(16'd16, st ? 16'd2 : 16'd1, 32'(n));
        for (int i = 0; i < n; i++) begin
            send_byte(fb[i], 1'b0);
            if (i == stall_at) begin
                save = rdy_mode;
                rdy_mode = 1;
                s_valid = 1'b1;
                s_data  = fb[i+1];
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_s_ready", 32'(s_ready), 32'd0);
                    chk("stall_m_valid", 32'(m_valid), 32'd1);
                    chk("stall_m_data", 32'(m_data), 32'({fb[i], fb[i-1]}));
                    chk("stall_bytes_left", bytes_left, 32'(n - i - 1));
                end
                rdy_mode = save;
            end
        end
        wait_done();
        chk("end_bytes_left", bytes_left, 32'd0);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("end_flags", 32'({busy, fault, s_ready, p_rst_n}), 32'd0);
        do_abort();
    endtask

    task automatic hdr_fault(input logic [15:0] bd, input logic [15:0] nc, input bit fmt,
                             input logic [1:0] experr);
        do_start();
        send_byte(hdr_b[0], 1'b1);
        send_byte(hdr_b[1], 1'b1);
        @(negedge clk);
        if (fmt) fmt_error = 1'b1;
        else begin bit_depth = bd; num_channels = nc; hdr_valid = 1'b1; end
        @(posedge clk); #1;
        fmt_error = 1'b0; hdr_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("fault_flag", 32'(fault), 32'd1);
        chk("fault_err_code", 32'(err_code), 32'(experr));
        chk("fault_quiet", 32'({done, busy, s_ready, p_rst_n}), 32'd0);
        do_abort();
    endtask

    task automatic interrupt_file(input bit use_reset);
        fill_rand(12);
        push_model(1'b1, 12);
        rdy_mode = 0;
        begin_file(16'd16, 16'd2, 32'd12);
        for (int i = 0; i < 5; i++) send_byte(fb[i], 1'b0);
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        intr = 1'b1;
        if (use_reset) begin
            rst_n = 1'b0;
            @(negedge clk);
            chk("rst_mid_m_data", 32'(m_data), 32'd0);
            rst_n = 1'b1;
        end else begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
        end
        chk("intr_m_valid", 32'(m_valid), 32'd0);
        chk("intr_bytes_left", bytes_left, 32'd0);
        chk("intr_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        intr = 1'b0;
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        fill_rand(10);
        run_file(1'b1, -1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        hdr_b[0] = 8'h52; hdr_b[1] = 8'h49; hdr_b[2] = 8'h46; hdr_b[3] = 8'h46;
        @(negedge clk);
        chk("reset_outs", 32'({s_ready, p_valid, p_rst_n, m_valid, m_chan, m_last,
                               busy, done, fault, err_code}), 32'd0);
        chk("reset_m_data", 32'(m_data), 32'd0);
        chk("reset_bytes_left", bytes_left, 32'd0);
        rst_n = 1'b1;

        // abort wins over start
        @(posedge clk); #1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort_beats_start", 32'({busy, p_rst_n}), 32'd0);

        // mono 34 12 78 56
        rdy_mode = 2;
        fb = '{8'h34, 8'h12, 8'h78, 8'h56};
        run_file(1'b0, -1);
        // stereo 8 bytes, chan alternates
        fb = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        run_file(1'b1, -1);
        // back-pressure: second sample held for 5 cycles
        fb = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        run_file(1'b1, 3);
        // odd size, trailing byte dropped
        fb = '{8'hAA, 8'hBB, 8'hCC};
        run_file(1'b0, -1);
        // empty chunk
        fb.delete();
        run_file(1'b0, -1);
        // size exactly at the limit
        rdy_mode = 0;
        fill_rand(int'(MAXB));
        run_file(1'b1, -1);

        hdr_fault(16'd16, 16'd1, 1'b1, 2'd1);
        hdr_fault(16'd24, 16'd1, 1'b0, 2'd2);
        hdr_fault(16'd16, 16'd3, 1'b0, 2'd2);
        hdr_fault(16'd16, 16'd0, 1'b0, 2'd2);

        // oversize chunk: just above the limit and via the top size byte
        begin_file(16'd16, 16'd1, MAXB + 32'd1);
        @(negedge clk);
        chk("oversize_fault", 32'({fault, err_code}), 32'({1'b1, 2'd3}));
        do_abort();
        begin_file(16'd16, 16'd2, 32'h0100_0000);
        @(negedge clk);
        chk("oversize_hi_fault", 32'({fault, err_code}), 32'({1'b1, 2'd3}));
        do_abort();

        interrupt_file(1'b0);
        interrupt_file(1'b1);

        for (int t = 0; t < 12; t++) begin
            rdy_mode = ($urandom_range(0, 1) != 0) ? 0 : 2;
            fill_rand($urandom_range(0, 21));
            run_file(1'($urandom_range(0, 1)), -1);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
